// File: rtl/codec_intf.sv
// rtl/codec_intf.sv - I2S codec clocking, ADC deserializer and DAC serializer
// Frame timing derives entirely from an 11-bit free-running counter.
module codec_intf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SDout,
   input  logic [15:0] lft_out,
   input  logic [15:0] rht_out,
   output logic        MCLK,
   output logic        SCLK,
   output logic        LRCLK,
   output logic        RSTn,
   output logic        SDin,
   output logic [15:0] lft_in,
   output logic [15:0] rht_in,
   output logic        valid
);

   typedef enum logic [1:0] {CODEC_RST, SETTLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic        rstn_q, rstn_d;
   logic [15:0] rx_shift_q, rx_shift_d;
   logic [15:0] lft_stage_q, lft_stage_d;
   logic [15:0] lft_in_q, lft_in_d;
   logic [15:0] rht_in_q, rht_in_d;
   logic        valid_q, valid_d;
   logic [15:0] lft_hold_q, lft_hold_d;
   logic [15:0] rht_hold_q, rht_hold_d;
   logic [15:0] tx_shift_q, tx_shift_d;
   logic        sdin_q, sdin_d;
   logic [4:0]  slot, slot_nxt;
   logic        data_slot, shift_slot, data_slot_nxt;

   always_comb begin
      cnt_d         = cnt_q + 11'd1;
      slot          = cnt_q[9:5];
      slot_nxt      = cnt_d[9:5];
      data_slot     = (slot != 5'd0) && (slot <= 5'd16);
      shift_slot    = (slot != 5'd0) && (slot <= 5'd15);
      data_slot_nxt = (slot_nxt != 5'd0) && (slot_nxt <= 5'd16);

      state_d     = state_q;
      rstn_d      = rstn_q;
      rx_shift_d  = rx_shift_q;
      lft_stage_d = lft_stage_q;
      lft_in_d    = lft_in_q;
      rht_in_d    = rht_in_q;
      valid_d     = 1'b0;
      lft_hold_d  = lft_hold_q;
      rht_hold_d  = rht_hold_q;
      tx_shift_d  = tx_shift_q;

      // Startup sequencing advances once per frame, on the counter wrap
      if (cnt_q == 11'h7FF) begin
         case (state_q)
            CODEC_RST: begin
               state_d = SETTLE;
               rstn_d  = 1'b1;
            end
            SETTLE:  state_d = RUN;
            default: state_d = RUN;
         endcase
      end

      if ((cnt_q[4:0] == 5'h0F) && data_slot)
         rx_shift_d = {rx_shift_q[14:0], SDout};

      if (cnt_q == 11'h210)
         lft_stage_d = rx_shift_q;

      // Outputs update only alongside valid so they stay stable all frame
      if ((cnt_q == 11'h610) && (state_q == RUN)) begin
         lft_in_d = lft_stage_q;
         rht_in_d = rx_shift_q;
         valid_d  = 1'b1;
      end

      if (cnt_q == 11'h01F) begin
         lft_hold_d = lft_out;
         rht_hold_d = rht_out;
         tx_shift_d = lft_out;
      end else if (cnt_q == 11'h41F) begin
         tx_shift_d = rht_hold_q;
      end else if ((cnt_q[4:0] == 5'h1F) && shift_slot) begin
         tx_shift_d = {tx_shift_q[14:0], 1'b0};
      end

      sdin_d = data_slot_nxt ? tx_shift_d[15] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= CODEC_RST;
         cnt_q       <= 11'd0;
         rstn_q      <= 1'b0;
         rx_shift_q  <= 16'd0;
         lft_stage_q <= 16'd0;
         lft_in_q    <= 16'd0;
         rht_in_q    <= 16'd0;
         valid_q     <= 1'b0;
         lft_hold_q  <= 16'd0;
         rht_hold_q  <= 16'd0;
         tx_shift_q  <= 16'd0;
         sdin_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rstn_q      <= rstn_d;
         rx_shift_q  <= rx_shift_d;
         lft_stage_q <= lft_stage_d;
         lft_in_q    <= lft_in_d;
         rht_in_q    <= rht_in_d;
         valid_q     <= valid_d;
         lft_hold_q  <= lft_hold_d;
         rht_hold_q  <= rht_hold_d;
         tx_shift_q  <= tx_shift_d;
         sdin_q      <= sdin_d;
      end
   end

   assign MCLK   = cnt_q[1];
   assign SCLK   = cnt_q[4];
   assign LRCLK  = cnt_q[10];
   assign RSTn   = rstn_q;
   assign SDin   = sdin_q;
   assign lft_in = lft_in_q;
   assign rht_in = rht_in_q;
   assign valid  = valid_q;

endmodule

// File: tb/tb_codec_intf.sv
// tb/tb_codec_intf.sv - frame-level vector bench for codec_intf
// Each table entry covers one full 2048-cycle frame.
module tb_codec_intf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        SDout;
   logic [15:0] lft_out, rht_out;
   logic        MCLK, SCLK, LRCLK, RSTn, SDin, valid;
   logic [15:0] lft_in, rht_in;

   codec_intf dut (
      .clk(clk), .rst_n(rst_n), .SDout(SDout), .lft_out(lft_out), .rht_out(rht_out),
      .MCLK(MCLK), .SCLK(SCLK), .LRCLK(LRCLK), .RSTn(RSTn), .SDin(SDin),
      .lft_in(lft_in), .rht_in(rht_in), .valid(valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] lo;
      logic [15:0] ro;
      logic        apply;
      logic        late;
      logic [15:0] lo_late;
      logic [15:0] sd_l;
      logic [15:0] sd_r;
      logic        noise;
      logic        exp_valid;
      logic [15:0] exp_sl;
      logic [15:0] exp_sr;
   } vec_t;

   vec_t vecs[9];
   int   total  = 0;
   int   passed = 0;
   int   t      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else
         passed++;
   endtask

   function automatic logic sd_bit(input logic [10:0] c, input logic [15:0] l,
                                   input logic [15:0] r, input logic noise);
      int s;
      logic [15:0] w;
      s = int'(c[9:5]);
      w = c[10] ? r : l;
      if (s >= 1 && s <= 16)
         return w[4'(16 - s)];
      return noise ? (c[0] ^ c[5]) : 1'b0;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_mclk"},  32'(MCLK),   32'd0);
      check({tag, "_sclk"},  32'(SCLK),   32'd0);
      check({tag, "_lrclk"}, 32'(LRCLK),  32'd0);
      check({tag, "_rstn"},  32'(RSTn),   32'd0);
      check({tag, "_sdin"},  32'(SDin),   32'd0);
      check({tag, "_valid"}, 32'(valid),  32'd0);
      check({tag, "_lft"},   32'(lft_in), 32'd0);
      check({tag, "_rht"},   32'(rht_in), 32'd0);
   endtask

   // Called at #1 after the edge that starts a frame (DUT cnt == 0)
   task automatic run_frame(input int k);
      vec_t v;
      logic [10:0] c;
      logic [15:0] wl, wr, li, ri, prev_li, prev_ri;
      logic        prev_sd;
      int vc, vpos, extra, clkerr, rsterr, glitch, sdchg, s;
      v = vecs[k];
      wl = 0; wr = 0; li = 0; ri = 0;
      vc = 0; vpos = -1; extra = 0; clkerr = 0; rsterr = 0; glitch = 0; sdchg = 0;
      prev_li = lft_in; prev_ri = rht_in; prev_sd = SDin;
      for (int i = 0; i < 2048; i++) begin
         c = 11'(i);
         s = int'(c[9:5]);
         if (MCLK !== c[1] || SCLK !== c[4] || LRCLK !== c[10]) clkerr++;
         if (RSTn !== (t >= 2048)) rsterr++;
         if (valid === 1'b1) begin
            vc++; vpos = i; li = lft_in; ri = rht_in;
         end else if (lft_in !== prev_li || rht_in !== prev_ri) begin
            glitch++;
         end
         if (SDin !== prev_sd && c[4:0] != 5'd0) sdchg++;
         if (s >= 1 && s <= 16) begin
            if (c[4:0] == 5'h10) begin
               if (c[10]) wr = {wr[14:0], SDin};
               else       wl = {wl[14:0], SDin};
            end
         end else if (SDin !== 1'b0) begin
            extra++;
         end
         prev_li = lft_in; prev_ri = rht_in; prev_sd = SDin;
         if (i == 0 && v.apply) begin
            lft_out = v.lo;
            rht_out = v.ro;
         end
         if (i == 32'h20 && v.late) lft_out = v.lo_late;
         SDout = sd_bit(c, v.sd_l, v.sd_r, v.noise);
         @(posedge clk);
         #1;
         t++;
      end
      check($sformatf("f%0d_clocks", k),    32'(clkerr), 32'd0);
      check($sformatf("f%0d_rstn", k),      32'(rsterr), 32'd0);
      check($sformatf("f%0d_valid_cnt", k), 32'(vc), 32'(v.exp_valid));
      check($sformatf("f%0d_sdin_l", k),    32'(wl), 32'(v.exp_sl));
      check($sformatf("f%0d_sdin_r", k),    32'(wr), 32'(v.exp_sr));
      check($sformatf("f%0d_sdin_idle", k), 32'(extra), 32'd0);
      check($sformatf("f%0d_sdin_edge", k), 32'(sdchg), 32'd0);
      if (v.exp_valid) begin
         check($sformatf("f%0d_valid_pos", k), 32'(vpos), 32'h611);
         check($sformatf("f%0d_lft_in", k),    32'(li), 32'(v.sd_l));
         check($sformatf("f%0d_rht_in", k),    32'(ri), 32'(v.sd_r));
         check($sformatf("f%0d_stable", k),    32'(glitch), 32'd0);
      end
   endtask

   initial begin
      vecs[0] = '{lo:16'h8001, ro:16'h7FFE, apply:1, late:0, lo_late:0, sd_l:16'hA5C3, sd_r:16'h5A3C,
                  noise:0, exp_valid:0, exp_sl:16'h8001, exp_sr:16'h7FFE};
      vecs[1] = '{lo:16'h8001, ro:16'h7FFE, apply:1, late:0, lo_late:0, sd_l:16'hA5C3, sd_r:16'h5A3C,
                  noise:0, exp_valid:0, exp_sl:16'h8001, exp_sr:16'h7FFE};
      vecs[2] = '{lo:16'h8001, ro:16'h7FFE, apply:1, late:0, lo_late:0, sd_l:16'hA5C3, sd_r:16'h5A3C,
                  noise:0, exp_valid:1, exp_sl:16'h8001, exp_sr:16'h7FFE};
      vecs[3] = '{lo:16'h0000, ro:16'hFFFF, apply:1, late:0, lo_late:0, sd_l:16'h0000, sd_r:16'h0000,
                  noise:1, exp_valid:1, exp_sl:16'h0000, exp_sr:16'hFFFF};
      vecs[4] = '{lo:16'h1111, ro:16'h4321, apply:1, late:1, lo_late:16'h2222, sd_l:16'hFFFF, sd_r:16'h0001,
                  noise:0, exp_valid:1, exp_sl:16'h1111, exp_sr:16'h4321};
      vecs[5] = '{lo:16'h0000, ro:16'h0000, apply:0, late:0, lo_late:0, sd_l:16'h1234, sd_r:16'h8000,
                  noise:1, exp_valid:1, exp_sl:16'h2222, exp_sr:16'h4321};
      vecs[6] = '{lo:16'hABCD, ro:16'h0F0F, apply:1, late:0, lo_late:0, sd_l:16'hA5C3, sd_r:16'h5A3C,
                  noise:0, exp_valid:0, exp_sl:16'hABCD, exp_sr:16'h0F0F};
      vecs[7] = '{lo:16'h0000, ro:16'h0000, apply:0, late:0, lo_late:0, sd_l:16'hA5C3, sd_r:16'h5A3C,
                  noise:0, exp_valid:0, exp_sl:16'hABCD, exp_sr:16'h0F0F};
      vecs[8] = '{lo:16'hABCD, ro:16'h0F0F, apply:1, late:0, lo_late:0, sd_l:16'hC3A5, sd_r:16'h3C5A,
                  noise:1, exp_valid:1, exp_sl:16'hABCD, exp_sr:16'h0F0F};

      rst_n = 1'b0; SDout = 1'b0; lft_out = 16'd0; rht_out = 16'd0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("por");
      rst_n = 1'b1;
      t = 0;
      for (int k = 0; k < 6; k++) run_frame(k);

      for (int i = 0; i < 32'h300; i++) begin
         SDout = sd_bit(11'(i), 16'hA5C3, 16'h5A3C, 1'b0);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      check_reset_vals("mid");
      repeat (5) @(posedge clk);
      #1;
      check_reset_vals("hold");
      rst_n = 1'b1;
      t = 0;
      for (int k = 6; k < 9; k++) run_frame(k);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
